// File: rtl/combo_lock_fsm.sv
// -----------------------------------------------------------------------------
// combo_lock_fsm
//
// Combination-lock controller fed by the single-cycle fall_edge pulses of four
// keypad synchronizers. It collects CODE_LEN digits per entry and compares them
// against CODE, which is packed 2 bits per digit with digit 0 entered first.
// A correct entry holds unlock for UNLOCK_CYCLES cycles. A wrong entry pulses
// error for one cycle. MAX_FAILS consecutive wrong entries hold locked_out for
// LOCKOUT_CYCLES cycles.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   press[3:0]     in   one-cycle button pulses, bit b = digit b
//   clear          in   one-cycle pulse, abandons the partial entry
//   unlock         out  high while unlocked
//   error          out  one-cycle pulse on completion of a wrong entry
//   locked_out     out  high during lockout
//   digits_entered out  digits accepted in the current entry
// -----------------------------------------------------------------------------
module combo_lock_fsm #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0] CODE           = 8'hE4,
    parameter int                    UNLOCK_CYCLES  = 8,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [3:0]                      press,
    input  logic                            clear,
    output logic                            unlock,
    output logic                            error,
    output logic                            locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   digits_entered
);

    localparam int CW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic           r_match;
    logic [FW-1:0]  r_fails;
    logic [TW-1:0]  r_timer;
    logic           r_unlock;
    logic           r_error;
    logic           r_locked_out;

    logic [1:0]     w_digit;
    logic           w_press_ok;
    logic           w_last;
    logic [FW-1:0]  w_fails_next;

    // Expected digit for the current position.
    always_comb begin
        w_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (r_count == CW'(i)) begin
                w_digit = CODE[2*i +: 2];
            end
        end
    end

    // A single comparison against the one-hot expected pattern rejects both
    // a wrong digit and a multi-button press.
    assign w_press_ok   = (press == (4'b0001 << w_digit));
    assign w_last       = (r_count == CW'(CODE_LEN - 1));
    assign w_fails_next = (r_fails == FW'(MAX_FAILS)) ? r_fails : r_fails + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_ENTRY;
            r_count      <= '0;
            r_match      <= 1'b1;
            r_fails      <= '0;
            r_timer      <= '0;
            r_unlock     <= 1'b0;
            r_error      <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    if (clear) begin
                        r_count <= '0;
                        r_match <= 1'b1;
                    end else if (press != '0) begin
                        if (w_last) begin
                            r_count <= '0;
                            r_match <= 1'b1;
                            if (r_match && w_press_ok) begin
                                r_state  <= ST_UNLOCKED;
                                r_timer  <= TW'(UNLOCK_CYCLES);
                                r_fails  <= '0;
                                r_unlock <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                                r_fails <= w_fails_next;
                                if (w_fails_next == FW'(MAX_FAILS)) begin
                                    r_state      <= ST_LOCKOUT;
                                    r_timer      <= TW'(LOCKOUT_CYCLES);
                                    r_locked_out <= 1'b1;
                                end
                            end
                        end else begin
                            r_count <= r_count + 1'b1;
                            r_match <= r_match & w_press_ok;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (r_timer == TW'(1)) begin
                        r_state  <= ST_ENTRY;
                        r_timer  <= '0;
                        r_unlock <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_timer == TW'(1)) begin
                        r_state      <= ST_ENTRY;
                        r_timer      <= '0;
                        r_fails      <= '0;
                        r_locked_out <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    assign unlock         = r_unlock;
    assign error          = r_error;
    assign locked_out     = r_locked_out;
    assign digits_entered = r_count;

endmodule

// File: doc/combo_lock_fsm.md
# combo_lock_fsm

Combination-lock controller that consumes the single-cycle falling-edge pulses produced by the per-button `sync` synchronizers and decides whether the entered digit sequence matches a stored code. It sits directly downstream of four `sync` instances, one per keypad button. It drives the unlock indication, a wrong-code error pulse and a timed lockout after repeated failures. All outputs are registered; the block is the sole reader of the `fall_edge` pulses.

## Interface
- CODE_LEN, 4, number of digits in the combination (1..8)
- CODE, 8'hE4, combination packed 2 bits per digit; digit i at [2i+1:2i], digit 0 entered first (default sequence 0,1,2,3); width CODE_LEN*2
- UNLOCK_CYCLES, 8, cycles `unlock` stays high after a correct entry (>=1)
- MAX_FAILS, 3, consecutive wrong entries that trigger lockout (>=1)
- LOCKOUT_CYCLES, 16, cycles the lockout lasts (>=1)

- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- press  input  4  button pulses from `sync` `fall_edge` outputs; bit b = digit b; each pulse is one cycle wide
- clear  input  1  one-cycle pulse, abandons the partial entry
- unlock  output  1  high while in UNLOCKED
- error  output  1  one-cycle pulse on completion of a wrong entry
- locked_out  output  1  high while in LOCKOUT
- digits_entered  output  $clog2(CODE_LEN+1)  digits accepted in the current entry

## Operation
- States: ENTRY, UNLOCKED, LOCKOUT. Reset state ENTRY; count=0, match flag=1, fail counter=0, timer=0; all outputs 0.
- ENTRY, press==0: no change.
- ENTRY, press non-zero: counts as one digit. Exactly one bit set and bit index equals CODE digit[count] -> match flag unchanged; otherwise (wrong digit or more than one bit set) match flag cleared. count increments.
- No early rejection: a wrong digit does not end the entry; the full CODE_LEN digits are always collected.
- On the press that makes count reach CODE_LEN:
  - match flag 1 -> UNLOCKED, timer=UNLOCK_CYCLES, fail counter=0.
  - match flag 0 -> error pulse, fail counter+1; if new value == MAX_FAILS -> LOCKOUT, timer=LOCKOUT_CYCLES; else stay ENTRY.
  - Either way count=0, match flag=1.
- clear in ENTRY: count=0, match flag=1; fail counter unchanged. clear and press in the same cycle: clear wins, press discarded.
- UNLOCKED: press and clear ignored; timer decrements; when timer reaches 1 the next state is ENTRY.
- LOCKOUT: press and clear ignored; timer decrements; on exit to ENTRY fail counter=0.
- digits_entered = count; reads 0 in UNLOCKED and LOCKOUT.
- Fail counter width $clog2(MAX_FAILS+1), saturates at MAX_FAILS, never wraps.
- Timer width $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1).

## Timing
- digits_entered updates the cycle after the press pulse is sampled.
- unlock rises on the clock edge that samples the final correct press; high for exactly UNLOCK_CYCLES cycles; press accepted again on the first cycle after unlock falls.
- error is high for exactly one cycle, on the edge that samples the final wrong press.
- locked_out rises on the same edge as the MAX_FAILS-th error pulse; high for exactly LOCKOUT_CYCLES cycles.
- Back-to-back presses on consecutive cycles are each counted.
- reset_n low at any time, including mid-entry, mid-unlock and mid-lockout: immediately (asynchronously) returns to reset state, outputs 0.

## Test plan
- Reset, then press pulses 1,2,4,8 (digits 0,1,2,3), one per 2 cycles -> digits_entered 1,2,3,0; unlock high for 8 cycles starting after the 4th press; error never asserted.
- Digits 0,1,3,3 -> one error pulse after the 4th press, unlock stays 0, digits_entered returns 0.
- Three wrong entries -> error pulses 3 times; locked_out high for 16 cycles from the 3rd; presses during lockout leave digits_entered at 0; a correct code after lockout -> unlock.
- Digits 0,1 then clear, then 0,1,2,3 -> clear zeroes digits_entered; unlock asserts with no error. Same cycle clear+press -> press ignored.
- press=4'b0011 as the first digit, followed by 1,2,3 -> error pulse; 2 wrong entries then a correct one -> fail counter cleared; 2 further wrong entries do not lock out.
- reset_n pulsed low mid-unlock and mid-lockout -> unlock/locked_out/error drop immediately to 0; digits_entered 0; a correct entry is accepted right after release.
